mac_array_2x2_seq: RTL and testbench

Sequencer for the 2x2 INT8 MAC array: accumulates a dot product of NUM_PAIRS input-channel pairs for 2 output channels.
- Accepts one weight/activation beat per cycle over a valid/ready stream.
- Drives the array and feeds the running sum back through acc_in.
- Returns the two 32-bit results over a valid/ready output stream.
- Sits between the operand buffer readers and the post-processing stage (bias/requant).

---
 rtl/dpu_mac_pkg.sv | 39 +++
 rtl/mac_array_2x2.sv | 41 ++++
 rtl/mac_array_2x2_seq.sv | 144 ++++++++++++++
 tb/tb_mac_array_2x2_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpu_mac_pkg.sv
// Shared types and constants for the DPU MAC sequencer and its 2x2 datapath.
package dpu_mac_pkg;

    localparam int ACC_W  = 32;
    localparam int DATA_W = 8;

    // Sequencer states; the encoding is exported on the debug port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } seq_state_t;

    // One operand beat: weights in row/column order, then activations.
    typedef struct packed {
        logic signed [DATA_W-1:0] w00;
        logic signed [DATA_W-1:0] w01;
        logic signed [DATA_W-1:0] w10;
        logic signed [DATA_W-1:0] w11;
        logic signed [DATA_W-1:0] a0;
        logic signed [DATA_W-1:0] a1;
    } mac2x2_operands_t;

    // Signed DATA_W x DATA_W product, sign-extended to the accumulator width.
    function automatic logic [ACC_W-1:0] sext_prod(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [2*DATA_W-1:0] ax;
        logic [2*DATA_W-1:0] bx;
        logic [2*DATA_W-1:0] p;
        ax = {{DATA_W{a[DATA_W-1]}}, a};
        bx = {{DATA_W{b[DATA_W-1]}}, b};
        p  = ax * bx;
        return {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
    endfunction

endpackage

// File: rtl/mac_array_2x2.sv
// 2x2 INT8 MAC datapath: on valid, registers acc_in plus the two dot-product
// terms per output channel; done pulses one cycle later with the new sums.
module mac_array_2x2
    import dpu_mac_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  mac2x2_operands_t ops,
    input  logic [ACC_W-1:0] acc_in0,
    input  logic [ACC_W-1:0] acc_in1,
    output logic             done,
    output logic [ACC_W-1:0] acc_out0,
    output logic [ACC_W-1:0] acc_out1
);

    logic [ACC_W-1:0] sum0;
    logic [ACC_W-1:0] sum1;

    // Channel 0 uses weight row 0, channel 1 uses weight row 1; wraps mod 2^32.
    always_comb begin
        sum0 = acc_in0 + sext_prod(ops.w00, ops.a0) + sext_prod(ops.w01, ops.a1);
        sum1 = acc_in1 + sext_prod(ops.w10, ops.a0) + sext_prod(ops.w11, ops.a1);
    end

    // Result registers and done flag; cleared so an aborted job leaves no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            acc_out0 <= '0;
            acc_out1 <= '0;
        end else begin
            done <= valid;
            if (valid) begin
                acc_out0 <= sum0;
                acc_out1 <= sum1;
            end
        end
    end

endmodule

// File: rtl/mac_array_2x2_seq.sv
// Sequencer for the 2x2 INT8 MAC array: accumulates NUM_PAIRS operand beats
// into two 32-bit output channels and hands the sums downstream.
//
// Handshakes: a beat or result transfers on a cycle where valid and ready are
// both high at the rising edge. in_ready depends only on state. Once out_valid
// rises, out_acc0/1 hold steady until the transfer, and out_valid drops the cycle
// after it.
module mac_array_2x2_seq
    import dpu_mac_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_pairs,
    input  logic [ACC_W-1:0]   acc_init0,
    input  logic [ACC_W-1:0]   acc_init1,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_w00,
    input  logic [DATA_W-1:0]  in_w01,
    input  logic [DATA_W-1:0]  in_w10,
    input  logic [DATA_W-1:0]  in_w11,
    input  logic [DATA_W-1:0]  in_a0,
    input  logic [DATA_W-1:0]  in_a1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_acc0,
    output logic [ACC_W-1:0]   out_acc1,
    output logic               busy,
    output seq_state_t         fsm_state
);

    seq_state_t       state;
    seq_state_t       next_state;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc_r0;
    logic [ACC_W-1:0] acc_r1;
    logic             fire;
    logic             last_beat;
    logic             launch;

    mac2x2_operands_t ops;
    logic             arr_rst_n;
    logic             arr_done;
    logic [ACC_W-1:0] arr_acc_in0;
    logic [ACC_W-1:0] arr_acc_in1;
    logic [ACC_W-1:0] arr_acc_out0;
    logic [ACC_W-1:0] arr_acc_out1;

    assign fire      = in_valid & in_ready;
    assign last_beat = fire && (cnt == CNT_W'(1));
    assign launch    = (state == IDLE) && start;
    assign arr_rst_n = ~rst;

    // Operands go straight from the input ports into the array.
    assign ops.w00 = in_w00;
    assign ops.w01 = in_w01;
    assign ops.w10 = in_w10;
    assign ops.w11 = in_w11;
    assign ops.a0  = in_a0;
    assign ops.a1  = in_a1;

    // Bypass the freshest sum while acc_r is still one cycle behind it.
    assign arr_acc_in0 = arr_done ? arr_acc_out0 : acc_r0;
    assign arr_acc_in1 = arr_done ? arr_acc_out1 : acc_r1;

    assign out_acc0  = acc_r0;
    assign out_acc1  = acc_r1;
    assign fsm_state = state;

    mac_array_2x2 u_array (
        .clk      (clk),
        .rst_n    (arr_rst_n),
        .valid    (fire),
        .ops      (ops),
        .acc_in0  (arr_acc_in0),
        .acc_in1  (arr_acc_in1),
        .done     (arr_done),
        .acc_out0 (arr_acc_out0),
        .acc_out1 (arr_acc_out1)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (num_pairs != '0) ? RUN : OUT;
            RUN:     if (last_beat) next_state = DRAIN;
            DRAIN:   next_state = OUT;
            OUT:     if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake and status outputs are pure functions of state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE:    busy      = 1'b0;
            RUN:     in_ready  = 1'b1;
            OUT:     out_valid = 1'b1;
            default: ;
        endcase
    end

    // Remaining-beat counter: loaded at launch, stepped down on each accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (launch) begin
            cnt <= num_pairs;
        end else if ((state == RUN) && fire) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Accumulators: seeded at launch, then follow every completed array beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r0 <= '0;
            acc_r1 <= '0;
        end else if (launch) begin
            acc_r0 <= acc_init0;
            acc_r1 <= acc_init1;
        end else if (arr_done) begin
            acc_r0 <= arr_acc_out0;
            acc_r1 <= arr_acc_out1;
        end
    end

endmodule

// File: tb/tb_mac_array_2x2_seq.sv
// Self-checking bench for mac_array_2x2_seq: directed vector table, a reset
// abort sequence and randomized jobs against a dot-product reference model.
module tb_mac_array_2x2_seq;
    import dpu_mac_pkg::*;

    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  num_pairs = '0;
    logic [31:0]       acc_init0 = '0;
    logic [31:0]       acc_init1 = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        in_w00 = '0;
    logic [7:0]        in_w01 = '0;
    logic [7:0]        in_w10 = '0;
    logic [7:0]        in_w11 = '0;
    logic [7:0]        in_a0 = '0;
    logic [7:0]        in_a1 = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_acc0;
    logic [31:0]       out_acc1;
    logic              busy;
    seq_state_t        fsm_state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic signed [7:0] w00;
        logic signed [7:0] w01;
        logic signed [7:0] w10;
        logic signed [7:0] w11;
        logic signed [7:0] a0;
        logic signed [7:0] a1;
    } beat_t;

    typedef struct {
        string            name;
        logic [CNT_W-1:0] n;
        logic [31:0]      i0;
        logic [31:0]      i1;
        beat_t            b;
        int               gap;
        int               hold;
        logic [31:0]      e0;
        logic [31:0]      e1;
    } vec_t;

    beat_t beats[$];
    vec_t  vt[5];

    mac_array_2x2_seq #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_pairs (num_pairs),
        .acc_init0 (acc_init0),
        .acc_init1 (acc_init1),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_w00    (in_w00),
        .in_w01    (in_w01),
        .in_w10    (in_w10),
        .in_w11    (in_w11),
        .in_a0     (in_a0),
        .in_a1     (in_a1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc0  (out_acc0),
        .out_acc1  (out_acc1),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog so a stuck handshake cannot hang the run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: init plus the sum of each beat's row dot product, mod 2^32.
    function automatic logic [31:0] model_sum(input logic [31:0] init, input bit ch);
        logic [31:0] s;
        int          p;
        s = init;
        foreach (beats[k]) begin
            if (!ch) p = int'(beats[k].w00) * int'(beats[k].a0) + int'(beats[k].w01) * int'(beats[k].a1);
            else     p = int'(beats[k].w10) * int'(beats[k].a0) + int'(beats[k].w11) * int'(beats[k].a1);
            s = s + p;
        end
        return s;
    endfunction

    task automatic drive_beat(input beat_t b);
        in_w00 = b.w00;
        in_w01 = b.w01;
        in_w10 = b.w10;
        in_w11 = b.w11;
        in_a0  = b.a0;
        in_a1  = b.a1;
    endtask

    // One job: launch, stream beats from the queue, hold the result, then accept it.
    task automatic run_job(input string tag, input logic [CNT_W-1:0] n,
                           input logic [31:0] i0, input logic [31:0] i1,
                           input int gap, input int hold,
                           input logic [31:0] e0, input logic [31:0] e1);
        int ready_cyc;
        int lat;
        bit stable;
        ready_cyc = 0;
        start = 1'b1;
        num_pairs = n;
        acc_init0 = i0;
        acc_init1 = i1;
        step();
        start = 1'b0;
        if (n == '0) begin
            check({tag, "_zero_lat_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_zero_no_ready"}, 32'(in_ready), 32'd0);
        end else begin
            for (int k = 0; k < int'(n); k++) begin
                if (k > 0) begin
                    for (int g = 0; g < gap; g++) begin
                        in_valid = 1'b0;
                        if (in_ready) ready_cyc++;
                        step();
                    end
                end
                drive_beat(beats[k]);
                in_valid = 1'b1;
                if (in_ready) ready_cyc++;
                step();
            end
            in_valid = 1'b0;
            // Now one cycle after the last accepted beat.
            lat = 1;
            while (!out_valid && lat < 20) begin
                if (in_ready) ready_cyc++;
                step();
                lat++;
            end
            check({tag, "_latency"}, 32'(lat), 32'd2);
            check({tag, "_ready_cycles"}, 32'(ready_cyc), 32'(int'(n) + gap * (int'(n) - 1)));
        end
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            if (!out_valid || out_acc0 !== e0 || out_acc1 !== e1) stable = 1'b0;
            start = (h == 0);
            num_pairs = 16'd1;
            step();
            start = 1'b0;
        end
        if (hold > 0) check({tag, "_hold_stable"}, 32'(stable), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_acc0"}, out_acc0, e0);
        check({tag, "_acc1"}, out_acc1, e1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset block.
        repeat (3) step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acc0", out_acc0, 32'd0);
        check("rst_state", {30'd0, fsm_state}, {30'd0, IDLE});
        rst = 1'b0;
        step();

        // Directed vectors.
        vt[0] = '{"one_beat", 16'd1, 32'd0, 32'd0, '{8'sd3, 8'sd4, -8'sd2, 8'sd5, 8'sd10, -8'sd1},
                  0, 0, 32'd26, -32'sd25};
        vt[1] = '{"full_scale", 16'd4, 32'd0, 32'd0, '{8'sd127, 8'sd127, 8'sd127, 8'sd127, -8'sd128, -8'sd128},
                  0, 0, -32'sd130048, -32'sd130048};
        vt[2] = '{"gapped", 16'd3, 32'd100, -32'sd100, '{8'sd1, 8'sd1, 8'sd2, 8'sd2, 8'sd1, 8'sd1},
                  2, 0, 32'd106, -32'sd88};
        vt[3] = '{"zero_pairs", 16'd0, 32'd7, -32'sd9, '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0},
                  0, 0, 32'd7, -32'sd9};
        // 0x7FFFFFF0 + 127*127 (0x3F01) wraps to 0x80003EF1.
        vt[4] = '{"hold_wrap", 16'd1, 32'h7FFFFFF0, 32'd0, '{8'sd127, 8'sd0, 8'sd0, 8'sd0, 8'sd127, 8'sd0},
                  0, 5, 32'h80003EF1, 32'd0};
        for (int i = 0; i < 5; i++) begin
            beats.delete();
            for (int k = 0; k < int'(vt[i].n); k++) beats.push_back(vt[i].b);
            run_job(vt[i].name, vt[i].n, vt[i].i0, vt[i].i1, vt[i].gap, vt[i].hold, vt[i].e0, vt[i].e1);
        end

        // Reset in the middle of a 4-beat job after 2 accepted beats.
        beats.delete();
        start = 1'b1;
        num_pairs = 16'd4;
        acc_init0 = 32'd55;
        acc_init1 = 32'd66;
        step();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive_beat('{8'sd9, 8'sd9, 8'sd9, 8'sd9, 8'sd9, 8'sd9});
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_acc0", out_acc0, 32'd0);
        check("abort_acc1", out_acc1, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        beats.push_back('{8'sd1, 8'sd0, 8'sd0, 8'sd0, 8'sd1, 8'sd0});
        run_job("after_abort", 16'd1, 32'd0, 32'd0, 0, 0, 32'd1, 32'd0);

        // Randomized jobs against the reference model.
        for (int j = 0; j < 25; j++) begin
            logic [CNT_W-1:0] n;
            logic [31:0]      i0;
            logic [31:0]      i1;
            beat_t            b;
            n  = CNT_W'($urandom_range(0, 6));
            i0 = $urandom;
            i1 = $urandom;
            beats.delete();
            for (int k = 0; k < int'(n); k++) begin
                b = beat_t'({$urandom, $urandom});
                beats.push_back(b);
            end
            run_job($sformatf("rand%0d", j), n, i0, i1, $urandom_range(0, 2), $urandom_range(0, 3),
                    model_sum(i0, 1'b0), model_sum(i1, 1'b1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
